// File: rtl/ltsm_pkg.sv
// Shared LTSM types: SBINIT responder state encoding, sideband message layout and message constants.
package ltsm_pkg;

    localparam int unsigned SB_MSG_W  = 64;
    localparam int unsigned SB_ID_W   = 16;
    localparam int unsigned SB_DATA_W = SB_MSG_W - SB_ID_W;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_WAIT_OOR       = 3'd1,
        ST_SEND_OOR       = 3'd2,
        ST_WAIT_DONE_REQ  = 3'd3,
        ST_SEND_DONE_RESP = 3'd4,
        ST_DONE           = 3'd5,
        ST_TRAINERROR     = 3'd6
    } sbinit_resp_state_t;

    // Message id sits in the low 16 bits as {msgcode, msgsubcode}
    typedef struct packed {
        logic [SB_DATA_W-1:0] data;
        logic [SB_ID_W-1:0]   id;
    } sb_msg_t;

    localparam logic [SB_ID_W-1:0] SB_ID_OOR       = 16'h9100;
    localparam logic [SB_ID_W-1:0] SB_ID_DONE_REQ  = 16'h9501;
    localparam logic [SB_ID_W-1:0] SB_ID_DONE_RESP = 16'h9A01;

    localparam logic [SB_MSG_W-1:0] SB_OOR_MSG       = {{SB_DATA_W{1'b0}}, SB_ID_OOR};
    localparam logic [SB_MSG_W-1:0] SB_DONE_RESP_MSG = {{SB_DATA_W{1'b0}}, SB_ID_DONE_RESP};

endpackage

// File: rtl/ltsm_timeout_cnt.sv
// Saturating wait-state timer. expired is registered and rises one increment early, so a state
// can leave on the very edge where the count reaches TIMEOUT_CYCLES-1.
module ltsm_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 800000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] EXP_AT  = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            expired <= (EXP_AT == '0);
        end else if (inc && (count != CNT_MAX)) begin
            count   <= CNT_W'(count + 1'b1);
            expired <= (CNT_W'(count + 1'b1) >= EXP_AT);
        end
    end

endmodule

// File: rtl/ltsm_sbinit_responder.sv
// Partner-side SBINIT responder: answers Out-of-Reset and SBINIT done req over the sideband.
// Build option SBINIT_RESP_STRICT_EN: an unexpected message id in a wait state raises TRAINERROR.
module ltsm_sbinit_responder
    import ltsm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 800000
) (
    input  logic                clk_100MHz,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                start_i,
    input  logic [SB_MSG_W-1:0] SB_msg_i,
    input  logic                SB_msg_valid_i,
    output logic                SB_msg_req_o,
    output logic [SB_MSG_W-1:0] SB_msg_o,
    output logic                SB_TX_valid_o,
    input  logic                SB_TX_valid_ack_i,
    output logic                done_o,
    output logic                error_o,
    output logic [2:0]          state_o
);

`ifdef SBINIT_RESP_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    sbinit_resp_state_t   state;
    sb_msg_t              rx_msg;
    logic [SB_ID_W-1:0]   want_id_c;
    logic                 in_wait_c;
    logic                 in_send_c;
    logic                 consume_c;
    logic                 expected_c;
    logic                 bad_c;
    logic                 ack_c;
    logic                 tmr_clear_c;
    logic                 tmr_expired;
    logic                 unused_rx_data;

    assign rx_msg         = sb_msg_t'(SB_msg_i);
    assign unused_rx_data = ^rx_msg.data;

    assign in_wait_c  = (state == ST_WAIT_OOR) || (state == ST_WAIT_DONE_REQ);
    assign in_send_c  = (state == ST_SEND_OOR) || (state == ST_SEND_DONE_RESP);
    assign want_id_c  = (state == ST_WAIT_OOR) ? SB_ID_OOR : SB_ID_DONE_REQ;
    assign consume_c  = in_wait_c && SB_msg_valid_i && SB_msg_req_o;
    assign expected_c = consume_c && (rx_msg.id == want_id_c);
    assign bad_c      = STRICT && consume_c && !expected_c;
    assign ack_c      = in_send_c && SB_TX_valid_ack_i;

    // Timer restarts on every state change and idles at zero outside the wait/send states
    assign tmr_clear_c = !enable_i || !(in_wait_c || in_send_c) || expected_c || ack_c
                         || tmr_expired || bad_c;

    ltsm_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clear      (tmr_clear_c),
        .inc        (in_wait_c || in_send_c),
        .expired    (tmr_expired)
    );

    always_ff @(posedge clk_100MHz) begin
        if (reset || !enable_i) begin
            state         <= ST_IDLE;
            SB_msg_req_o  <= 1'b0;
            SB_msg_o      <= '0;
            SB_TX_valid_o <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state        <= ST_WAIT_OOR;
                        SB_msg_req_o <= 1'b1;
                    end
                end
                ST_WAIT_OOR, ST_WAIT_DONE_REQ: begin
                    if (expected_c) begin
                        SB_msg_req_o  <= 1'b0;
                        SB_TX_valid_o <= 1'b1;
                        if (state == ST_WAIT_OOR) begin
                            state    <= ST_SEND_OOR;
                            SB_msg_o <= SB_OOR_MSG;
                        end else begin
                            state    <= ST_SEND_DONE_RESP;
                            SB_msg_o <= SB_DONE_RESP_MSG;
                        end
                    end else if (tmr_expired || bad_c) begin
                        state        <= ST_TRAINERROR;
                        SB_msg_req_o <= 1'b0;
                        error_o      <= 1'b1;
                    end
                end
                ST_SEND_OOR, ST_SEND_DONE_RESP: begin
                    if (ack_c) begin
                        SB_TX_valid_o <= 1'b0;
                        SB_msg_o      <= '0;
                        if (state == ST_SEND_OOR) begin
                            state        <= ST_WAIT_DONE_REQ;
                            SB_msg_req_o <= 1'b1;
                        end else begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end
                    end else if (tmr_expired) begin
                        state         <= ST_TRAINERROR;
                        SB_TX_valid_o <= 1'b0;
                        SB_msg_o      <= '0;
                        error_o       <= 1'b1;
                    end
                end
                ST_DONE, ST_TRAINERROR: begin
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_ltsm_sbinit_responder.sv
// Directed self-checking bench for ltsm_sbinit_responder (TIMEOUT_CYCLES = 64).
module tb_ltsm_sbinit_responder;

    localparam int unsigned TO = 64;

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        enable_i;
    logic        start_i;
    logic [63:0] SB_msg_i;
    logic        SB_msg_valid_i;
    logic        SB_msg_req_o;
    logic [63:0] SB_msg_o;
    logic        SB_TX_valid_o;
    logic        SB_TX_valid_ack_i;
    logic        done_o;
    logic        error_o;
    logic [2:0]  state_o;

    int          checks = 0;
    int          errors = 0;
    int          valid_cycles = 0;
    logic [63:0] tx_log[$];

    always #5 clk_100MHz = ~clk_100MHz;

    ltsm_sbinit_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_100MHz        (clk_100MHz),
        .reset             (reset),
        .enable_i          (enable_i),
        .start_i           (start_i),
        .SB_msg_i          (SB_msg_i),
        .SB_msg_valid_i    (SB_msg_valid_i),
        .SB_msg_req_o      (SB_msg_req_o),
        .SB_msg_o          (SB_msg_o),
        .SB_TX_valid_o     (SB_TX_valid_o),
        .SB_TX_valid_ack_i (SB_TX_valid_ack_i),
        .done_o            (done_o),
        .error_o           (error_o),
        .state_o           (state_o)
    );

    // Log every accepted TX message and every cycle TX valid is high
    always @(posedge clk_100MHz) begin
        if (SB_TX_valid_o) valid_cycles++;
        if (SB_TX_valid_o && SB_TX_valid_ack_i) tx_log.push_back(SB_msg_o);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_100MHz);
    endtask

    task automatic send_rx(input logic [15:0] id);
        SB_msg_i       = {48'h0, id};
        SB_msg_valid_i = 1'b1;
        tick();
        SB_msg_valid_i = 1'b0;
        SB_msg_i       = '0;
    endtask

    // Hold ack low for n-1 cycles (TX must stay stable), then ack for one cycle
    task automatic ack_after(input int n, input logic [63:0] exp_msg, input string tag);
        logic stable;
        stable = 1'b1;
        for (int i = 1; i < n; i++) begin
            tick();
            if (!(SB_TX_valid_o === 1'b1 && SB_msg_o === exp_msg)) stable = 1'b0;
        end
        check({tag, "_tx_stable"}, 64'(stable), 64'd1);
        SB_TX_valid_ack_i = 1'b1;
        tick();
        SB_TX_valid_ack_i = 1'b0;
    endtask

    task automatic run_nominal(input string tag);
        int base;
        base     = tx_log.size();
        enable_i = 1'b1;
        start_i  = 1'b1;
        tick();
        check({tag, "_wait_oor"}, 64'(state_o), 64'd1);
        check({tag, "_req_hi"}, 64'(SB_msg_req_o), 64'd1);
        start_i = 1'b0;
        send_rx(16'h9100);
        check({tag, "_send_oor"}, 64'(state_o), 64'd2);
        check({tag, "_oor_valid"}, 64'(SB_TX_valid_o), 64'd1);
        check({tag, "_oor_msg"}, SB_msg_o, 64'h9100);
        check({tag, "_req_lo"}, 64'(SB_msg_req_o), 64'd0);
        ack_after(3, 64'h9100, {tag, "_oor"});
        check({tag, "_wait_dreq"}, 64'(state_o), 64'd3);
        check({tag, "_oor_valid_lo"}, 64'(SB_TX_valid_o), 64'd0);
        check({tag, "_dreq_req"}, 64'(SB_msg_req_o), 64'd1);
        send_rx(16'h9501);
        check({tag, "_send_dresp"}, 64'(state_o), 64'd4);
        check({tag, "_dresp_msg"}, SB_msg_o, 64'h9A01);
        check({tag, "_dresp_valid"}, 64'(SB_TX_valid_o), 64'd1);
        ack_after(3, 64'h9A01, {tag, "_dresp"});
        check({tag, "_done_state"}, 64'(state_o), 64'd5);
        check({tag, "_done"}, 64'(done_o), 64'd1);
        check({tag, "_no_err"}, 64'(error_o), 64'd0);
        check({tag, "_done_valid"}, 64'(SB_TX_valid_o), 64'd0);
        check({tag, "_done_req"}, 64'(SB_msg_req_o), 64'd0);
        check({tag, "_tx_count"}, 64'(tx_log.size() - base), 64'd2);
        if (tx_log.size() >= base + 2) begin
            check({tag, "_tx0"}, tx_log[base], 64'h9100);
            check({tag, "_tx1"}, tx_log[base+1], 64'h9A01);
        end
    endtask

    initial begin
        int base;
        int vbase;
        reset             = 1'b1;
        enable_i          = 1'b0;
        start_i           = 1'b0;
        SB_msg_i          = '0;
        SB_msg_valid_i    = 1'b0;
        SB_TX_valid_ack_i = 1'b0;
        repeat (3) tick();

        check("rst_state", 64'(state_o), 64'd0);
        check("rst_req", 64'(SB_msg_req_o), 64'd0);
        check("rst_msg", SB_msg_o, 64'd0);
        check("rst_valid", 64'(SB_TX_valid_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(error_o), 64'd0);

        reset = 1'b0;
        tick();
        check("idle_hold", 64'(state_o), 64'd0);

        run_nominal("nom");
        tick();
        check("done_sticky", 64'(done_o), 64'd1);
        enable_i = 1'b0;
        tick();
        check("dis_state", 64'(state_o), 64'd0);
        check("dis_done", 64'(done_o), 64'd0);

        // Timeout with no RX traffic
        enable_i = 1'b1;
        start_i  = 1'b1;
        tick();
        check("to_wait", 64'(state_o), 64'd1);
        base  = tx_log.size();
        vbase = valid_cycles;
        repeat (TO - 2) tick();
        check("to_pre_err", 64'(error_o), 64'd0);
        check("to_pre_state", 64'(state_o), 64'd1);
        tick();
        check("to_err", 64'(error_o), 64'd1);
        check("to_state", 64'(state_o), 64'd6);
        check("to_req", 64'(SB_msg_req_o), 64'd0);
        check("to_no_tx", 64'(tx_log.size() - base), 64'd0);
        check("to_no_valid", 64'(valid_cycles - vbase), 64'd0);
        tick();
        check("to_err_sticky", 64'(error_o), 64'd1);
        enable_i = 1'b0;
        start_i  = 1'b0;
        tick();
        check("to_clr_err", 64'(error_o), 64'd0);
        check("to_clr_state", 64'(state_o), 64'd0);

        // Unexpected message id in WAIT_OOR
        enable_i = 1'b1;
        start_i  = 1'b1;
        tick();
        start_i = 1'b0;
        send_rx(16'h1234);
`ifdef SBINIT_RESP_STRICT_EN
        check("bad_state", 64'(state_o), 64'd6);
        check("bad_err", 64'(error_o), 64'd1);
`else
        check("bad_state", 64'(state_o), 64'd1);
        check("bad_req", 64'(SB_msg_req_o), 64'd1);
        check("bad_err", 64'(error_o), 64'd0);
        send_rx(16'h9100);
        check("bad_then_oor", 64'(state_o), 64'd2);
        check("bad_then_msg", SB_msg_o, 64'h9100);
        ack_after(2, 64'h9100, "bad");
        check("bad_then_wdreq", 64'(state_o), 64'd3);
`endif
        enable_i = 1'b0;
        tick();

        // Backpressure on the OOR response
        enable_i = 1'b1;
        start_i  = 1'b1;
        tick();
        start_i = 1'b0;
        send_rx(16'h9100);
        base = tx_log.size();
        ack_after(11, 64'h9100, "bp");
        check("bp_state", 64'(state_o), 64'd3);
        check("bp_one_tx", 64'(tx_log.size() - base), 64'd1);
        repeat (3) tick();
        check("bp_no_resend", 64'(tx_log.size() - base), 64'd1);
        check("bp_state_hold", 64'(state_o), 64'd3);
        enable_i = 1'b0;
        tick();

        // Abort while TX valid, then a clean retry
        enable_i = 1'b1;
        start_i  = 1'b1;
        tick();
        start_i = 1'b0;
        send_rx(16'h9100);
        check("ab_valid", 64'(SB_TX_valid_o), 64'd1);
        enable_i = 1'b0;
        tick();
        check("ab_state", 64'(state_o), 64'd0);
        check("ab_valid_lo", 64'(SB_TX_valid_o), 64'd0);
        check("ab_msg_lo", SB_msg_o, 64'd0);
        run_nominal("ab");
        enable_i = 1'b0;
        tick();

        // Ack lands on the same edge the timer expires in SEND_OOR
        enable_i = 1'b1;
        start_i  = 1'b1;
        tick();
        start_i = 1'b0;
        send_rx(16'h9100);
        repeat (TO - 2) tick();
        check("race_pre_state", 64'(state_o), 64'd2);
        check("race_pre_valid", 64'(SB_TX_valid_o), 64'd1);
        SB_TX_valid_ack_i = 1'b1;
        tick();
        SB_TX_valid_ack_i = 1'b0;
        check("race_state", 64'(state_o), 64'd3);
        check("race_err", 64'(error_o), 64'd0);
        check("race_valid", 64'(SB_TX_valid_o), 64'd0);
        check("race_req", 64'(SB_msg_req_o), 64'd1);

        // Synchronous reset from a busy state
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_state", 64'(state_o), 64'd0);
        check("rst2_req", 64'(SB_msg_req_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
